// File: rtl/mem_responder_pkg.sv
// Shared types and helpers for the memory-bus responder.
package mem_responder_pkg;

    localparam int unsigned WORD_BYTES = 4;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StResp = 2'd2
    } state_e;

    // Word index of a byte address: bits [aw_words+1:2], zero-extended.
    function automatic logic [31:0] word_index(input logic [31:0] adr,
                                               input int unsigned aw_words);
        logic [31:0] mask;
        mask = (32'd1 << aw_words) - 32'd1;
        return (adr >> $clog2(WORD_BYTES)) & mask;
    endfunction

endpackage

// File: rtl/mem_responder_ram.sv
// Single-port synchronous word RAM with registered read; contents are never reset.
module mem_responder_ram #(
    parameter int unsigned Aw = 6
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [Aw-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);
    localparam int unsigned Depth = 1 << Aw;

    logic [31:0] mem_q [Depth];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        rdata_o <= mem_q[addr_i];
    end

endmodule

// File: rtl/mem_responder.sv
// Memory-bus slave: wait-state FSM, word RAM and a first-write status mailbox.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int unsigned AW_WORDS    = 6,
    parameter int unsigned WAIT        = 2,
    parameter logic [31:0] MAILBOX_ADR = 32'd84,
    parameter logic [31:0] EXPECT      = 32'd7
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] adr,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        ack,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        err_align
);
    localparam bit         NoWait   = (WAIT == 0);
    localparam logic [3:0] WaitLoad = NoWait ? 4'd0 : 4'(WAIT - 1);

    state_e        state_q;
    logic [3:0]    cnt_q;
    logic [31:0]   cap_adr_q;
    logic [31:0]   cap_wd_q;
    logic          cap_we_q;
    logic          ack_q;
    logic          busy_q;
    logic          done_q;
    logic          pass_q;
    logic          err_align_q;
    logic          rd_sel_q;

    logic [31:0]         idx_full;
    logic [AW_WORDS-1:0] ram_addr;
    logic [31:0]         ram_rdata;
    logic                ram_we;
    logic                unused_idx_bits;

    // In IDLE the RAM is addressed by the live bus so a zero-wait read has data in RESP.
    assign idx_full        = word_index((state_q == StIdle) ? adr : cap_adr_q, AW_WORDS);
    assign ram_addr        = idx_full[AW_WORDS-1:0];
    assign unused_idx_bits = ^idx_full[31:AW_WORDS];
    assign ram_we          = (state_q == StResp) && cap_we_q && (cap_adr_q[1:0] == 2'b00);

    mem_responder_ram #(
        .Aw (AW_WORDS)
    ) u_ram (
        .clk_i   (clk),
        .we_i    (ram_we),
        .addr_i  (ram_addr),
        .wdata_i (cap_wd_q),
        .rdata_o (ram_rdata)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            cnt_q       <= 4'd0;
            cap_adr_q   <= 32'd0;
            cap_wd_q    <= 32'd0;
            cap_we_q    <= 1'b0;
            ack_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            err_align_q <= 1'b0;
            rd_sel_q    <= 1'b0;
        end else begin
            ack_q    <= 1'b0;
            rd_sel_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (req) begin
                        cap_adr_q <= adr;
                        cap_we_q  <= we;
                        cap_wd_q  <= wd;
                        cnt_q     <= WaitLoad;
                        busy_q    <= 1'b1;
                        if (adr[1:0] != 2'b00) begin
                            err_align_q <= 1'b1;
                        end
                        if (NoWait) begin
                            state_q  <= StResp;
                            ack_q    <= 1'b1;
                            rd_sel_q <= !we && (adr[1:0] == 2'b00);
                        end else begin
                            state_q <= StWait;
                        end
                    end
                end
                StWait: begin
                    if (cnt_q == 4'd0) begin
                        state_q  <= StResp;
                        ack_q    <= 1'b1;
                        rd_sel_q <= !cap_we_q && (cap_adr_q[1:0] == 2'b00);
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                StResp: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                    if (cap_we_q && (cap_adr_q == MAILBOX_ADR) && !done_q) begin
                        done_q <= 1'b1;
                        pass_q <= (cap_wd_q == EXPECT);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign rd        = rd_sel_q ? ram_rdata : 32'd0;
    assign ack       = ack_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_align = err_align_q;

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Synthesizable data-memory responder: the slave end of the processor's memory bus.
- Accepts one word read or write per request and returns data plus a one-cycle ack after a programmable wait-state latency.
- Contains a status mailbox that latches the first write to a designated address and reports pass or fail in hardware.
- Sits between the multicycle datapath's memory port and on-chip storage; used in self-checking FPGA and standalone runs without a simulator monitor.

Parameters:
- AW_WORDS, 6: log2 of memory depth in 32-bit words (64 words).
- WAIT, 2: wait states between request capture and ack, legal range 0..15.
- MAILBOX_ADR, 84: byte address of the status mailbox.
- EXPECT, 7: value that, written to the mailbox, signals pass.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low (0 = in reset).
- req  in  1  request valid; held by the requester until ack.
- we  in  1  1 = write, 0 = read; sampled with req.
- adr  in  32  byte address; sampled with req.
- wd  in  32  write data; sampled with req.
- rd  out  32  read data; valid only in the ack cycle.
- ack  out  1  one-cycle completion pulse.
- busy  out  1  transaction in progress (WAIT or RESP).
- done  out  1  sticky; set by the first mailbox write.
- pass  out  1  sticky; value of (first mailbox wd == EXPECT).
- err_align  out  1  sticky; set by any request with adr[1:0] != 0.

Behaviour:
- Reset (reset=0, asynchronous):
  - FSM goes to IDLE.
  - rd=0, ack=0, busy=0, done=0, pass=0, err_align=0, wait counter=0.
  - Memory array is not cleared; contents persist across reset.
- FSM states are IDLE, WAIT and RESP.
- IDLE:
  - If req=1, capture adr, we and wd into internal registers.
  - Load the counter with WAIT-1.
  - Go to WAIT if WAIT>0; otherwise go straight to RESP.
- WAIT:
  - busy=1; decrement the counter each cycle.
  - Go to RESP when the counter reaches 0.
  - Changes on req, adr, we or wd are ignored; the captured values govern the transaction.
- RESP:
  - busy=1, ack=1 for exactly this cycle.
  - Write: mem[cap_adr[AW_WORDS+1:2]] <= cap_wd at the end of the cycle; rd=0.
  - Read: rd = mem[cap_adr[AW_WORDS+1:2]], driven from a register.
  - Always return to IDLE.
- Latency from the req-sampling edge to ack is WAIT+1 cycles. With WAIT=0, ack appears on the cycle after req is sampled.
- Back-to-back requests: a req still high in the cycle after ack is sampled as a new request. The requester must deassert req during the ack cycle if it has no further request. Minimum spacing is one IDLE cycle per transaction.
- Address handling:
  - Only bits [AW_WORDS+1:2] index the memory; higher bits alias (wrap-around).
  - Misaligned request (adr[1:0] != 0): still completes with ack after the normal latency. There is no memory write, rd=0, and err_align is set sticky.
- Mailbox:
  - A write completing in RESP with cap_adr == MAILBOX_ADR (full 32-bit compare) while done=0 sets done=1 and pass=(cap_wd==EXPECT).
  - The memory word is also written.
  - Later mailbox writes update memory only; done and pass are frozen.
  - A read of MAILBOX_ADR is a normal read.
- Reset mid-transaction: the transaction is abandoned, no ack is issued and no write occurs. A write already committed in a prior RESP is retained.
- A read-after-write to the same address in consecutive transactions returns the new data.

Decomposition:
- Package mem_responder_pkg holds:
  - state enum (IDLE=2'd0, WAIT=2'd1, RESP=2'd2);
  - WORD_BYTES=4;
  - a function word_index(adr) returning adr[AW_WORDS+1:2].
- One sub-module, mem_responder_ram: single-port synchronous array with write enable and registered read, no reset.
- FSM, counter, capture registers and mailbox logic stay in the top module.

Test Plan:
- Reset then idle: hold reset=0 for 12 ns, release → all outputs 0; with req=0, ack stays 0 for 20 cycles.
- Write/read, WAIT=2: write adr=16, wd=32'hDEADBEEF → ack on the 3rd cycle after sampling, busy=1 for 3 cycles. Then read adr=16 → rd=32'hDEADBEEF with ack.
- Mailbox pass and freeze: write adr=80, wd=3 → done=0. Write adr=84, wd=7 → done=1, pass=1 in the cycle after ack. Write adr=84, wd=9 → pass remains 1, but a read of 84 returns 9.
- Mailbox fail: after reset, write adr=84, wd=5 → done=1, pass=0.
- Misaligned and alias, WAIT=0: write adr=18 → ack the next cycle, err_align=1, and a read of 16 is unchanged. Write adr=256+4 with AW_WORDS=6 → a read of adr=4 returns the written value.
- Reset mid-wait, WAIT=5: issue a write to adr=8 with wd=1 (adr=8 previously held 0), pull reset low in the 3rd WAIT cycle → no ack, and a read of adr=8 after release returns 0.
